// File: rtl/stage_chain_ctrl_if.sv
// stage_chain_ctrl_if: control/status bundle between a frame sequencer and its host
interface stage_chain_ctrl_if #(
  parameter int N_STAGE = 11,
  parameter int CNT_W = 16
);
  logic start;
  logic abort;
  logic [N_STAGE-1:0] end_i;
  logic [CNT_W-1:0] timeout_lim;
  logic [N_STAGE-1:0] en_o;
  logic [N_STAGE-1:0] en_d1_o;
  logic start_ready;
  logic busy;
  logic done;
  logic [CNT_W-1:0] frame_cnt;
  logic err;
  logic [$clog2(N_STAGE)-1:0] err_stage;
  logic err_ovr;
  modport master (
    output start, abort, end_i, timeout_lim,
    input en_o, en_d1_o, start_ready, busy, done, frame_cnt, err, err_stage, err_ovr
  );
  modport slave (
    input start, abort, end_i, timeout_lim,
    output en_o, en_d1_o, start_ready, busy, done, frame_cnt, err, err_stage, err_ovr
  );
endinterface

// File: rtl/stage_chain_ctrl.sv
// stage_chain_ctrl: walks frames through a chain of stages with one-deep pending slots, timeout and overrun faults
module stage_chain_ctrl #(
  parameter int N_STAGE = 11,
  parameter int CNT_W = 16,
  parameter bit PIPE = 1'b0
) (
  input logic clk,
  input logic rstn,
  stage_chain_ctrl_if.slave bus
);
  localparam int SW = $clog2(N_STAGE);
  logic [N_STAGE-1:0] en, en_d1, pend, acc, hand, ovr, tmo, flt;
  logic [N_STAGE-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0] frame_cnt;
  logic [SW-1:0] err_stage, fidx;
  logic err, err_ovr, done, fovr, busy, ready, kill;
  assign busy = |{en, pend};
  assign ready = !err && (PIPE ? !(en[0] || pend[0]) : !busy);
  assign acc = bus.end_i & en;
  assign hand = {acc[N_STAGE-2:0], bus.start & ready};
  assign ovr = hand & pend;
  assign flt = ovr | tmo;
  assign kill = bus.abort || |flt;
  always_comb begin
    tmo = '0;
    for (int i = 0; i < N_STAGE; i++)
      tmo[i] = en[i] && bus.timeout_lim != '0 && cnt[i] == bus.timeout_lim - CNT_W'(1) && !acc[i];
  end
  // lowest faulting stage wins; overrun is reported when a stage has both faults
  always_comb begin
    fidx = '0;
    fovr = 1'b0;
    for (int i = N_STAGE - 1; i >= 0; i--)
      if (flt[i]) begin
        fidx = SW'(i);
        fovr = ovr[i];
      end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      en <= '0;
      en_d1 <= '0;
      pend <= '0;
      cnt <= '0;
      done <= 1'b0;
      frame_cnt <= '0;
      err <= 1'b0;
      err_stage <= '0;
      err_ovr <= 1'b0;
    end else if (kill) begin
      en <= '0;
      en_d1 <= '0;
      pend <= '0;
      cnt <= '0;
      done <= 1'b0;
      err <= !bus.abort;
      err_stage <= bus.abort ? '0 : fidx;
      err_ovr <= !bus.abort && fovr;
    end else begin
      // an ending stage always drops for a cycle before a pending job restarts it
      en <= (en & ~acc) | (~en & (pend | hand));
      pend <= en & (pend | hand);
      en_d1 <= en;
      done <= acc[N_STAGE-1];
      frame_cnt <= frame_cnt + CNT_W'(acc[N_STAGE-1]);
      for (int i = 0; i < N_STAGE; i++) cnt[i] <= en[i] ? cnt[i] + CNT_W'(1) : '0;
    end
  end
  assign bus.en_o = en;
  assign bus.en_d1_o = en_d1;
  assign bus.start_ready = ready;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.frame_cnt = frame_cnt;
  assign bus.err = err;
  assign bus.err_stage = err_stage;
  assign bus.err_ovr = err_ovr;
endmodule

// File: tb/tb_stage_chain_ctrl.sv
// tb_stage_chain_ctrl: two chain configurations driven by shared stimulus, checked each cycle against a job-level model
module tb_stage_chain_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [7:0] ends = '0;
  logic [3:0] lim = '0;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always #5 clk = ~clk;

  stage_chain_ctrl_if #(.N_STAGE(3), .CNT_W(4)) if0 ();
  stage_chain_ctrl_if #(.N_STAGE(5), .CNT_W(4)) if1 ();
  assign if0.start = start;
  assign if0.abort = abort;
  assign if0.end_i = ends[2:0];
  assign if0.timeout_lim = lim;
  assign if1.start = start;
  assign if1.abort = abort;
  assign if1.end_i = ends[4:0];
  assign if1.timeout_lim = lim;
  stage_chain_ctrl #(.N_STAGE(3), .CNT_W(4), .PIPE(1'b0)) u0 (.clk(clk), .rstn(rstn), .bus(if0));
  stage_chain_ctrl #(.N_STAGE(5), .CNT_W(4), .PIPE(1'b1)) u1 (.clk(clk), .rstn(rstn), .bus(if1));

  // model state per instance: which stages hold a running job, which hold a queued one
  bit m_en[2][8];
  bit m_pend[2][8];
  bit m_d1[2][8];
  int m_cnt[2][8];
  bit m_err[2];
  int m_es[2];
  bit m_eo[2];
  bit m_done[2];
  int m_fc[2];

  task automatic clear_model(input int k, input bit full);
    for (int i = 0; i < 8; i++) begin
      m_en[k][i] = 0;
      m_pend[k][i] = 0;
      m_d1[k][i] = 0;
      m_cnt[k][i] = 0;
    end
    m_err[k] = 0;
    m_es[k] = 0;
    m_eo[k] = 0;
    m_done[k] = 0;
    if (full) m_fc[k] = 0;
  endtask

  function automatic bit m_busy(input int k, input int n);
    bit b = 0;
    for (int i = 0; i < n; i++) b = b | m_en[k][i] | m_pend[k][i];
    return b;
  endfunction

  function automatic bit m_ready(input int k, input int n, input bit pipe);
    return !m_err[k] && (pipe ? !(m_en[k][0] || m_pend[k][0]) : !m_busy(k, n));
  endfunction

  task automatic step(input int k, input int n, input bit pipe, input bit s, input bit a,
                      input logic [7:0] e, input logic [3:0] l, input bit r);
    bit acc[8];
    bit hand[8];
    int fi;
    bit fo;
    fi = -1;
    fo = 0;
    for (int i = 0; i < 8; i++) begin
      acc[i] = 0;
      hand[i] = 0;
    end
    if (!r || a) begin
      clear_model(k, !r);
      return;
    end
    for (int i = 0; i < n; i++) acc[i] = e[i] && m_en[k][i];
    hand[0] = s && m_ready(k, n, pipe);
    for (int i = 1; i < n; i++) hand[i] = acc[i-1];
    for (int i = 0; i < n; i++)
      if (fi < 0) begin
        if (hand[i] && m_pend[k][i]) begin
          fi = i;
          fo = 1;
        end else if (l != 0 && m_en[k][i] && m_cnt[k][i] == int'(l) - 1 && !acc[i]) begin
          fi = i;
          fo = 0;
        end
      end
    if (fi >= 0) begin
      clear_model(k, 0);
      m_err[k] = 1;
      m_es[k] = fi;
      m_eo[k] = fo;
      return;
    end
    for (int i = 0; i < n; i++) begin
      m_d1[k][i] = m_en[k][i];
      m_cnt[k][i] = m_en[k][i] ? (m_cnt[k][i] + 1) % 16 : 0;
      if (acc[i]) begin
        m_en[k][i] = 0;
        m_pend[k][i] = m_pend[k][i] | hand[i];
      end else if (m_en[k][i]) begin
        m_pend[k][i] = m_pend[k][i] | hand[i];
      end else if (m_pend[k][i]) begin
        m_en[k][i] = 1;
        m_pend[k][i] = 0;
      end else begin
        m_en[k][i] = hand[i];
      end
    end
    m_done[k] = acc[n-1];
    m_fc[k] = (m_fc[k] + (acc[n-1] ? 1 : 0)) % 16;
  endtask

  task automatic cmp(input int k, input int n, input bit pipe, input logic [7:0] en, input logic [7:0] d1,
                     input logic sr, input logic bz, input logic dn, input logic [3:0] fc,
                     input logic er, input logic [2:0] es, input logic eo);
    logic [7:0] xe;
    logic [7:0] xd;
    logic [27:0] got;
    logic [27:0] exp;
    xe = '0;
    xd = '0;
    for (int i = 0; i < n; i++) begin
      xe[i] = m_en[k][i];
      xd[i] = m_d1[k][i];
    end
    got = {en, d1, sr, bz, dn, fc, er, es, eo};
    exp = {xe, xd, m_ready(k, n, pipe), m_busy(k, n), m_done[k], 4'(m_fc[k]), m_err[k], 3'(m_es[k]), m_eo[k]};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL model u%0d cyc %0d got=%h exp=%h", k, cyc, got, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick(input bit s, input bit a, input logic [7:0] e, input logic [3:0] l, input bit r);
    start = s;
    abort = a;
    ends = e;
    lim = l;
    rstn = r;
    step(0, 3, 0, s, a, e, l, r);
    step(1, 5, 1, s, a, e, l, r);
    @(negedge clk);
    cyc++;
    cmp(0, 3, 0, {5'b0, if0.en_o}, {5'b0, if0.en_d1_o}, if0.start_ready, if0.busy, if0.done,
        if0.frame_cnt, if0.err, {1'b0, if0.err_stage}, if0.err_ovr);
    cmp(1, 5, 1, {3'b0, if1.en_o}, {3'b0, if1.en_d1_o}, if1.start_ready, if1.busy, if1.done,
        if1.frame_cnt, if1.err, if1.err_stage, if1.err_ovr);
  endtask

  task automatic idle(input int n, input logic [3:0] l);
    for (int i = 0; i < n; i++) tick(0, 0, 8'h00, l, 1);
  endtask

  task automatic frame0();
    tick(1, 0, 8'h00, 4'd0, 1);
    tick(0, 0, 8'h01, 4'd0, 1);
    tick(0, 0, 8'h02, 4'd0, 1);
    tick(0, 0, 8'h04, 4'd0, 1);
  endtask

  initial begin
    clear_model(0, 1);
    clear_model(1, 1);
    tick(0, 0, 8'h00, 4'd0, 0);
    tick(1, 0, 8'h00, 4'd0, 0);
    lit("start_in_reset_u0", 8'(if0.en_o), 8'h00);
    lit("start_in_reset_u1", 8'(if1.en_o), 8'h00);
    idle(1, 4'd0);
    lit("ready_after_reset", 8'(if0.start_ready), 8'h01);

    tick(1, 0, 8'h00, 4'd0, 1);
    lit("seq_stage0", 8'(if0.en_o), 8'h01);
    idle(4, 4'd0);
    tick(0, 0, 8'h01, 4'd0, 1);
    lit("seq_stage1", 8'(if0.en_o), 8'h02);
    idle(3, 4'd0);
    tick(0, 0, 8'h02, 4'd0, 1);
    lit("seq_stage2", 8'(if0.en_o), 8'h04);
    idle(2, 4'd0);
    tick(0, 0, 8'h04, 4'd0, 1);
    lit("seq_end_en", 8'(if0.en_o), 8'h00);
    lit("seq_done", 8'(if0.done), 8'h01);
    lit("seq_frame_cnt", 8'(if0.frame_cnt), 8'h01);

    tick(0, 0, 8'h00, 4'd0, 0);
    tick(1, 0, 8'h00, 4'd0, 1);
    idle(4, 4'd0);
    tick(0, 0, 8'h01, 4'd0, 1);
    idle(1, 4'd0);
    tick(1, 0, 8'h00, 4'd0, 1);
    lit("pipe_two_frames", 8'(if1.en_o), 8'h03);
    tick(0, 0, 8'h01, 4'd0, 1);
    lit("pipe_pending_en", 8'(if1.en_o), 8'h02);
    tick(0, 0, 8'h02, 4'd0, 1);
    lit("pipe_gap", 8'(if1.en_o), 8'h04);
    idle(1, 4'd0);
    lit("pipe_restart", 8'(if1.en_o), 8'h06);

    tick(0, 0, 8'h00, 4'd0, 0);
    for (int f = 0; f < 3; f++) begin
      tick(1, 0, 8'h00, 4'd0, 1);
      tick(0, 0, 8'h01, 4'd0, 1);
    end
    lit("ovr_err", 8'(if1.err), 8'h01);
    lit("ovr_type", 8'(if1.err_ovr), 8'h01);
    lit("ovr_stage", 8'(if1.err_stage), 8'h01);
    lit("ovr_en", 8'(if1.en_o), 8'h00);
    tick(1, 0, 8'h01, 4'd0, 1);
    lit("err_sticky", 8'(if1.err), 8'h01);
    tick(0, 1, 8'h00, 4'd0, 1);
    lit("abort_err", 8'(if1.err), 8'h00);
    lit("abort_ready", 8'(if1.start_ready), 8'h01);

    tick(1, 0, 8'h00, 4'd4, 1);
    idle(3, 4'd4);
    lit("tmo_still_on", 8'(if0.en_o), 8'h01);
    idle(1, 4'd4);
    lit("tmo_en", 8'(if0.en_o), 8'h00);
    lit("tmo_err", 8'(if0.err), 8'h01);
    lit("tmo_type", 8'(if0.err_ovr), 8'h00);
    lit("tmo_stage", 8'(if0.err_stage), 8'h00);
    tick(0, 1, 8'h00, 4'd0, 1);

    tick(0, 0, 8'h02, 4'd0, 1);
    lit("stray_end", 8'(if0.busy), 8'h00);
    tick(1, 0, 8'h00, 4'd0, 1);
    tick(0, 0, 8'h00, 4'd0, 0);
    lit("midframe_reset_en", 8'(if0.en_o), 8'h00);
    lit("midframe_reset_cnt", 8'(if0.frame_cnt), 8'h00);

    for (int f = 0; f < 15; f++) frame0();
    lit("wrap_pre", 8'(if0.frame_cnt), 8'h0f);
    frame0();
    lit("wrap_done", 8'(if0.done), 8'h01);
    lit("wrap_cnt", 8'(if0.frame_cnt), 8'h00);

    for (int c = 0; c < 4000; c++) begin
      logic [7:0] e;
      logic [3:0] l;
      logic [2:0] pick;
      if (c % 200 == 0) begin
        pick = 3'($urandom_range(0, 4));
        l = (pick == 0 || pick == 1) ? 4'd0 : 4'(pick * 3);
        lim = l;
      end
      l = lim;
      e = '0;
      for (int i = 0; i < 5; i++) e[i] = ($urandom_range(0, 3) == 0);
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0, e, l, $urandom_range(0, 199) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stage_chain_ctrl.md
STAGE_CHAIN_CTRL -- requirements
Module: stage_chain_ctrl

Interface
REQ-001 SHALL have parameter N_STAGE, default 11, number of chained stages (conv, attention, pool) sequenced.
REQ-002 SHALL have parameter CNT_W, default 16, width of the timeout counters, timeout limit and frame counter.
REQ-003 SHALL have parameter PIPE, default 0; 0 = one frame in flight, 1 = overlapped frames.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request to launch a new frame into stage 0.
REQ-007 SHALL have port abort  input  1  clears the chain and any error.
REQ-008 SHALL have port end_i  input  N_STAGE  per-stage single-cycle completion pulses.
REQ-009 SHALL have port timeout_lim  input  CNT_W  maximum enabled cycles per stage; 0 disables timeout.
REQ-010 SHALL have port en_o  output  N_STAGE  per-stage enable.
REQ-011 SHALL have port en_d1_o  output  N_STAGE  en_o delayed one cycle.
REQ-012 SHALL have port start_ready  output  1  start is accepted this cycle when high.
REQ-013 SHALL have port busy  output  1  any en_o or pending bit set.
REQ-014 SHALL have port done  output  1  single-cycle frame completion pulse.
REQ-015 SHALL have port frame_cnt  output  CNT_W  completed frames, wraps modulo 2^CNT_W.
REQ-016 SHALL have port err  output  1  sticky fault flag.
REQ-017 SHALL have port err_stage  output  $clog2(N_STAGE)  stage index of the first fault.
REQ-018 SHALL have port err_ovr  output  1  fault type: 1 = overrun, 0 = timeout.

Function
REQ-019 SHALL accept start when start=1 and start_ready=1. Accepted start is the handoff into stage 0.
REQ-020 start_ready SHALL be !err && !busy when PIPE=0, and !err && !en_o[0] && !pending[0] when PIPE=1.
REQ-021 end_i[i] SHALL be accepted only when en_o[i]=1; end_i[i] with en_o[i]=0 SHALL be ignored and SHALL cause no state change.
REQ-022 Accepted end_i[i] at cycle t SHALL drive en_o[i]=0 at t+1. For i<N_STAGE-1 it SHALL also be the handoff into stage i+1.
REQ-023 Handoff to stage j at cycle t SHALL have three outcomes:
- en_o[j]=0 and pending[j]=0: en_o[j]=1 at t+1.
- otherwise, pending[j]=0: pending[j]=1 at t+1.
- otherwise: overrun fault on stage j.
REQ-024 If en_o[j]=0 and pending[j]=1 at cycle t, then at t+1 en_o[j]=1 and pending[j]=0. Clear has priority over a same-cycle handoff, so a stage always has at least one low cycle between jobs.
REQ-025 Accepted end_i[N_STAGE-1] at cycle t SHALL pulse done at t+1 and increment frame_cnt at t+1.
REQ-026 Each stage SHALL have a CNT_W timeout counter:
- Cleared whenever en_o[i]=0; increments each cycle en_o[i]=1.
- When timeout_lim!=0 and the counter equals timeout_lim-1 with no accepted end_i[i] that cycle, a timeout fault is raised on stage i.
REQ-027 On a fault at cycle t, at t+1:
- err=1; err_stage = lowest faulting index that cycle; err_ovr set per the fault type.
- All en_o, pending bits and counters cleared; done not pulsed.
REQ-028 While err=1, start and end_i SHALL be ignored. err, err_stage and err_ovr SHALL hold until abort or reset.
REQ-029 abort at cycle t SHALL, at t+1, clear en_o, pending, counters, err, err_stage and err_ovr; frame_cnt holds. abort overrides start, end_i and any fault in the same cycle.
REQ-030 en_d1_o SHALL equal en_o of the previous cycle; en_d1_o is also cleared at t+1 by abort or a fault.
REQ-031 When PIPE=0, the handoff target is always free by construction, so pending bits stay 0 and overrun cannot occur.

Reset
REQ-032 rstn=0 at a rising edge SHALL set every output and internal bit (pending, counters) to 0 on that edge, including during an active frame. start_ready is 1 from the first cycle after reset release.
REQ-033 A start sampled in the same cycle as rstn=0 SHALL be discarded.

Verification
REQ-034 N_STAGE=3, PIPE=0, lim=0:
- start at t0 -> en_o=001 at t0+1.
- end_i=001 at t0+5 -> en_o=010 at t0+6.
- end_i=010 at t0+9 -> en_o=100 at t0+10.
- end_i=100 at t0+12 -> en_o=000 and done=1 at t0+13, frame_cnt=1.
REQ-035 PIPE=1: second start at t0+7 -> en_o=011 at t0+8. The stage-0 end while stage 1 is still busy -> pending[1]=1. Stage 1 ends at t -> en_o[1]=0 at t+1, en_o[1]=1 at t+2.
REQ-036 PIPE=1: third frame reaches stage 1 with pending[1]=1 -> err=1, err_ovr=1, err_stage=1, en_o=000 next cycle. abort -> err=0, start_ready=1.
REQ-037 timeout_lim=4, start with no end_i -> en_o[0] high for exactly 4 cycles, then en_o=000, err=1, err_ovr=0, err_stage=0.
REQ-038 Stray end_i=010 while idle -> no change. rstn=0 mid-frame -> all outputs 0 next edge. frame_cnt=0xFFFF plus one frame -> 0x0000 with done=1.
